// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (8N1) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky io_parity_error output.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_rxd,
  output logic                          io_out_valid,
  input  logic                          io_out_ready,
  output logic [7:0]                    io_out_bits,
  output logic [$clog2(FIFO_DEPTH):0]   io_count,
  output logic                          io_overflow,
  output logic                          io_frame_error,
`ifdef UART_RX_PARITY_EN
  output logic                          io_parity_error,
`endif
  input  logic                          io_clear
);

  localparam int unsigned DIV_RAW = (CLOCK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_sync1, r_sync2;
  logic [PW-1:0]   r_prescale;
  logic [3:0]      r_tick, w_tick_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            w_line, w_tick, w_push, w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic            r_par_ok, w_par_ok_next, w_perr_set, r_perr;
`endif

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr, w_rd_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic [7:0]      r_out_bits, w_head_next;
  logic            r_valid, r_ovf, r_ferr;
  logic            w_full, w_pop, w_push_ok, w_ovf_set;

  assign w_line = r_sync2;
  assign w_tick = (r_state != S_IDLE) && (r_state != S_BREAK) &&
                  (r_prescale == PW'(DIV - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and receive-path strobes; every sample point is mid-bit
  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_push       = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_ok_next = r_par_ok;
    w_perr_set    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_line) begin
          w_state_next = S_START;
          w_tick_next  = 4'd0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_tick == 4'd7) begin
            w_tick_next = 4'd0;
            w_bit_next  = 3'd0;
            w_state_next = w_line ? S_IDLE : S_DATA;
          end else begin
            w_tick_next = r_tick + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_tick_next = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_shift_next = {w_line, r_shift[7:1]};
            w_bit_next   = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = S_PARITY;
`else
              w_state_next = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_tick_next = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_par_ok_next = ~(^{r_shift, w_line});
            w_perr_set    = ^{r_shift, w_line};
            w_state_next  = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_tick_next = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            if (w_line) begin
`ifdef UART_RX_PARITY_EN
              w_push = r_par_ok;
`else
              w_push = 1'b1;
`endif
              w_state_next = S_IDLE;
            end else begin
              w_ferr_set   = 1'b1;
              w_state_next = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (w_line) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Synchronizer, prescaler and receive datapath
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prescale <= '0;
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
    end else begin
      r_sync1 <= io_rxd;
      r_sync2 <= r_sync1;
      if (r_state == S_IDLE || r_state == S_BREAK || w_tick) r_prescale <= '0;
      else                                                   r_prescale <= r_prescale + PW'(1);
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = r_valid && io_out_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  // Head byte is registered, so bypass the memory when the push lands on the new head slot
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_push_ok && (r_wr_ptr == w_rd_next)) w_head_next = r_shift;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO control and sticky flags; a set event wins over io_clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_out_bits <= '0;
      r_ovf      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rd_ptr   <= w_rd_next;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      r_out_bits <= w_head_next;
      r_ovf      <= w_ovf_set  ? 1'b1 : (io_clear ? 1'b0 : r_ovf);
      r_ferr     <= w_ferr_set ? 1'b1 : (io_clear ? 1'b0 : r_ferr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_par_ok <= 1'b1;
      r_perr   <= 1'b0;
    end else begin
      r_par_ok <= w_par_ok_next;
      r_perr   <= w_perr_set ? 1'b1 : (io_clear ? 1'b0 : r_perr);
    end
  end
  assign io_parity_error = r_perr;
`endif

  assign io_out_valid   = r_valid;
  assign io_out_bits    = r_out_bits;
  assign io_count       = r_count;
  assign io_overflow    = r_ovf;
  assign io_frame_error = r_ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=1 (16-cycle bit time) with a 4-entry FIFO.
module tb_uart_rx_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       io_rxd = 1'b0;
  logic       io_out_ready = 1'b0;
  logic       io_clear = 1'b0;
  logic       io_out_valid;
  logic [7:0] io_out_bits;
  logic [2:0] io_count;
  logic       io_overflow;
  logic       io_frame_error;
`ifdef UART_RX_PARITY_EN
  logic       io_parity_error;
`endif

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .CLOCK_FREQ(100_000_000),
    .BAUD_RATE (6_250_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_rxd         (io_rxd),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_bits    (io_out_bits),
    .io_count       (io_count),
    .io_overflow    (io_overflow),
    .io_frame_error (io_frame_error),
`ifdef UART_RX_PARITY_EN
    .io_parity_error(io_parity_error),
`endif
    .io_clear       (io_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // One 8N1 frame, 16 negedges per bit; optionally pulses ready at negedge index ready_idx
  task automatic send_byte(input logic [7:0] data, input logic stop_bit,
                           input int ready_idx, output int first_valid);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    first_valid = -1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (first_valid < 0 && io_out_valid) first_valid = i;
      io_rxd = frame[i / 16];
      if (ready_idx >= 0) io_out_ready = (i == ready_idx);
    end
    @(negedge clock);
    io_rxd = 1'b1;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    io_rxd = 1'b0;
    repeat (10) @(negedge clock);
    reset  = 1'b1;
    io_rxd = 1'b1;
    repeat (200) @(negedge clock);
    n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", io_out_valid); end
    n_vec++; if (io_out_bits !== 8'h00) begin n_err++; $display("FAIL reset_bits got %h want 00", io_out_bits); end
    n_vec++; if (io_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", io_count); end
    n_vec++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", io_overflow); end
    n_vec++; if (io_frame_error !== 1'b0) begin n_err++; $display("FAIL reset_frame_error got %b want 0", io_frame_error); end
  endtask

  task automatic test_single;
    int fv;
    send_byte(8'hA5, 1'b1, -1, fv);
    n_vec++; if (fv !== 155) begin n_err++; $display("FAIL single_latency got %0d want 155", fv); end
    n_vec++; if (io_out_bits !== 8'hA5) begin n_err++; $display("FAIL single_bits got %h want a5", io_out_bits); end
    n_vec++; if (io_count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", io_count); end
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %b want 0", io_out_valid); end
    n_vec++; if (io_count !== 3'd0) begin n_err++; $display("FAIL single_pop_count got %0d want 0", io_count); end
  endtask

  task automatic test_false_start;
    @(negedge clock);
    io_rxd = 1'b0;
    repeat (4) @(negedge clock);
    io_rxd = 1'b1;
    repeat (40) @(negedge clock);
    n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got %b want 0", io_out_valid); end
    n_vec++; if (io_count !== 3'd0) begin n_err++; $display("FAIL glitch_count got %0d want 0", io_count); end
    n_vec++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL glitch_overflow got %b want 0", io_overflow); end
    n_vec++; if (io_frame_error !== 1'b0) begin n_err++; $display("FAIL glitch_frame_error got %b want 0", io_frame_error); end
  endtask

  task automatic test_overflow;
    int fv;
    logic [7:0] exp_q [4];
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, -1, fv);
    repeat (2) @(negedge clock);
    n_vec++; if (io_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", io_count); end
    n_vec++; if (io_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", io_overflow); end
    n_vec++; if (io_frame_error !== 1'b0) begin n_err++; $display("FAIL ovf_frame_error got %b want 0", io_frame_error); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (io_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_pop%0d_valid got %b want 1", k, io_out_valid); end
      n_vec++; if (io_out_bits !== exp_q[k]) begin n_err++; $display("FAIL ovf_pop%0d_bits got %h want %h", k, io_out_bits, exp_q[k]); end
      io_out_ready = 1'b1;
      @(negedge clock);
      io_out_ready = 1'b0;
    end
    n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained_valid got %b want 0", io_out_valid); end
    n_vec++; if (io_count !== 3'd0) begin n_err++; $display("FAIL ovf_drained_count got %0d want 0", io_count); end
    io_clear = 1'b1;
    @(negedge clock);
    io_clear = 1'b0;
    n_vec++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", io_overflow); end
  endtask

  task automatic test_frame_error;
    int fv;
    send_byte(8'h3C, 1'b0, -1, fv);
    io_rxd = 1'b0;
    repeat (40) @(negedge clock);
    io_rxd = 1'b1;
    repeat (20) @(negedge clock);
    send_byte(8'h5A, 1'b1, -1, fv);
    n_vec++; if (io_frame_error !== 1'b1) begin n_err++; $display("FAIL ferr_flag got %b want 1", io_frame_error); end
    n_vec++; if (io_count !== 3'd1) begin n_err++; $display("FAIL ferr_count got %0d want 1", io_count); end
    n_vec++; if (io_out_bits !== 8'h5A) begin n_err++; $display("FAIL ferr_bits got %h want 5a", io_out_bits); end
    n_vec++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL ferr_overflow got %b want 0", io_overflow); end
    io_out_ready = 1'b1;
    io_clear     = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    io_clear     = 1'b0;
    n_vec++; if (io_frame_error !== 1'b0) begin n_err++; $display("FAIL ferr_clear got %b want 0", io_frame_error); end
    n_vec++; if (io_count !== 3'd0) begin n_err++; $display("FAIL ferr_pop_count got %0d want 0", io_count); end
  endtask

  task automatic test_back_to_back;
    int fv;
    logic [7:0] fill_q [4];
    logic [7:0] exp_q [4];
    fill_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q  = '{8'h22, 8'h33, 8'h44, 8'h77};
    for (int k = 0; k < 4; k++) send_byte(fill_q[k], 1'b1, -1, fv);
    n_vec++; if (io_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", io_count); end
    n_vec++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL full_overflow got %b want 0", io_overflow); end
    send_byte(8'h77, 1'b1, 154, fv);
    n_vec++; if (io_count !== 3'd4) begin n_err++; $display("FAIL coincide_count got %0d want 4", io_count); end
    n_vec++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL coincide_overflow got %b want 0", io_overflow); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (io_out_valid !== 1'b1) begin n_err++; $display("FAIL coincide_pop%0d_valid got %b want 1", k, io_out_valid); end
      n_vec++; if (io_out_bits !== exp_q[k]) begin n_err++; $display("FAIL coincide_pop%0d_bits got %h want %h", k, io_out_bits, exp_q[k]); end
      io_out_ready = 1'b1;
      @(negedge clock);
      io_out_ready = 1'b0;
    end
    n_vec++; if (io_count !== 3'd0) begin n_err++; $display("FAIL coincide_drained_count got %0d want 0", io_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_overflow();
    test_frame_error();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
